// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer: operation codes, FSM states
// and small decode helpers used by the top, the divider and the bus interface.
package muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULT  = 2'd0,
      MD_OP_MULTU = 2'd1,
      MD_OP_DIV   = 2'd2,
      MD_OP_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MUL     = 3'd1,
      ST_DIV_RUN = 3'd2,
      ST_DIV_FIX = 3'd3,
      ST_DONE    = 3'd4
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input md_op_e op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-facing bus of the multiply/divide unit: op issue, flush, MTHI/MTLO
// writes and the HI/LO/busy/done results.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
   import muldiv_ctrl_pkg::*;

   logic             start;
   md_op_e           op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step.
// Sequencing and sign correction belong to the controller.
module muldiv_ctrl_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             last
);

   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH+1:0] trial;

   // Trial subtraction of the divisor from the shifted partial remainder;
   // the top bit is the borrow that decides whether to restore.
   assign trial = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvs_q};
   assign last  = (cnt_q == WIDTH'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem   <= '0;
         quo   <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem   <= '0;
         quo   <= dividend;
         dvs_q <= divisor;
         cnt_q <= WIDTH'(WIDTH);
      end else if (step && (cnt_q != '0)) begin
         if (!trial[WIDTH+1]) begin
            rem <= trial[WIDTH-1:0];
         end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
         end
         quo   <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Results and the done
// pulse land on the edge that ends the DONE state.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_ctrl_if.slave  md
);

   localparam int MCW      = $clog2(MUL_STAGES + 1);
   localparam int MUL_WAIT = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

   md_state_e          state, state_nx;
   logic               busy_w, accept, div_load, div_last, b_zero;
   logic               a_neg, b_neg, sgn;
   logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;
   logic [2*WIDTH-1:0] mul_pipe [MUL_STAGES];
   logic [MCW-1:0]     mul_cnt;
   logic               is_mul, neg_q, neg_r, done_q;
   logic [WIDTH-1:0]   div_hi, div_lo, hi_q, lo_q;

   assign busy_w   = (state == ST_MUL) || (state == ST_DIV_RUN) || (state == ST_DIV_FIX);
   assign accept   = md.start && !busy_w && !md.flush;
   assign b_zero   = (md.b == '0);
   assign div_load = accept && op_is_div(md.op) && !b_zero;

   assign sgn   = op_is_signed(md.op);
   assign a_neg = sgn && md.a[WIDTH-1];
   assign b_neg = sgn && md.b[WIDTH-1];
   assign a_mag = a_neg ? (~md.a) + WIDTH'(1) : md.a;
   assign b_mag = b_neg ? (~md.b) + WIDTH'(1) : md.b;

   // Sign-extending to 2*WIDTH lets one unsigned multiply serve both MULT and MULTU.
   assign a_ext = {{WIDTH{a_neg}}, md.a};
   assign b_ext = {{WIDTH{b_neg}}, md.b};
   assign prod  = a_ext * b_ext;

   assign md.busy = busy_w;
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

   muldiv_ctrl_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .step     (state == ST_DIV_RUN),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo      (quo),
      .rem      (rem),
      .last     (div_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            state_nx = ST_IDLE;
            if (accept) begin
               if (!op_is_div(md.op)) begin
                  state_nx = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
               end else if (b_zero) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_DIV_RUN;
               end
            end
         end
         ST_MUL:     if (mul_cnt == '0) state_nx = ST_DONE;
         ST_DIV_RUN: if (div_last)      state_nx = ST_DIV_FIX;
         ST_DIV_FIX: state_nx = ST_DONE;
         default:    state_nx = ST_IDLE;
      endcase
      if (md.flush) state_nx = ST_IDLE;
   end

   // The product is captured straight from the operands at accept and then
   // ripples down the pipe; the stage count fixes the multiply latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
      end else begin
         if (accept && !op_is_div(md.op)) mul_pipe[0] <= prod;
         for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q  <= 1'b0;
         is_mul  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         mul_cnt <= '0;
         div_hi  <= '0;
         div_lo  <= '0;
      end else begin
         done_q <= (state == ST_DONE);
         if (accept) begin
            is_mul  <= !op_is_div(md.op);
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            mul_cnt <= MCW'(MUL_WAIT);
            if (op_is_div(md.op) && b_zero) begin
               div_lo <= '1;
               div_hi <= md.a;
            end
         end else if ((state == ST_MUL) && (mul_cnt != '0)) begin
            mul_cnt <= mul_cnt - MCW'(1);
         end
         // Quotient takes the xor of the operand signs, remainder the dividend's.
         if (state == ST_DIV_FIX) begin
            div_lo <= neg_q ? (~quo) + WIDTH'(1) : quo;
            div_hi <= neg_r ? (~rem) + WIDTH'(1) : rem;
         end
      end
   end

   // Op results take priority over MTHI/MTLO, which are dropped while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state == ST_DONE) begin
         if (is_mul) begin
            {hi_q, lo_q} <= mul_pipe[MUL_STAGES-1];
         end else begin
            hi_q <= div_hi;
            lo_q <= div_lo;
         end
      end else if (!busy_w) begin
         if (md.hi_we) hi_q <= md.wdata;
         if (md.lo_we) lo_q <= md.wdata;
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: issued ops push expected HI/LO and done
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   typedef struct {
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   muldiv_ctrl_if #(.WIDTH(32)) md();

   muldiv_ctrl #(.WIDTH(32), .MUL_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && md.done === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            checkOutput({e.name, "_hi"}, md.hi, e.hi);
            checkOutput({e.name, "_lo"}, md.lo, e.lo);
         end
      end
   end

   task automatic applyStimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                input bit chk, input int lat, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo, input string name);
      exp_t e;
      if (chk) begin
         e.cyc  = cyc + 1 + lat;
         e.hi   = exp_hi;
         e.lo   = exp_lo;
         e.name = name;
         sb.push_back(e);
      end
      md.start = 1'b1;
      md.op    = op;
      md.a     = a;
      md.b     = b;
      @(posedge clk);
      #1;
      md.start = 1'b0;
   endtask

   task automatic mtWrite(input bit to_hi, input logic [31:0] data);
      md.hi_we = to_hi;
      md.lo_we = !to_hi;
      md.wdata = data;
      @(posedge clk);
      #1;
      md.hi_we = 1'b0;
      md.lo_we = 1'b0;
   endtask

   task automatic waitDrain(input int limit);
      int n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain_timeout: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      md.start = 1'b0;
      md.op    = MD_OP_MULT;
      md.a     = '0;
      md.b     = '0;
      md.flush = 1'b0;
      md.hi_we = 1'b0;
      md.lo_we = 1'b0;
      md.wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(md.busy), 32'd0);
      checkOutput("reset_done", 32'(md.done), 32'd0);
      checkOutput("reset_hi", md.hi, 32'd0);
      checkOutput("reset_lo", md.lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a divide clears everything and kills the op.
      mtWrite(1'b1, 32'hAAAA5555);
      mtWrite(1'b0, 32'h5555AAAA);
      checkOutput("mt_hi_init", md.hi, 32'hAAAA5555);
      checkOutput("mt_lo_init", md.lo, 32'h5555AAAA);
      applyStimulus(MD_OP_DIV, 32'd100, 32'd7, 1'b0, 0, '0, '0, "div_reset");
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midreset_busy", 32'(md.busy), 32'd0);
      checkOutput("midreset_done", 32'(md.done), 32'd0);
      checkOutput("midreset_hi", md.hi, 32'd0);
      checkOutput("midreset_lo", md.lo, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (45) @(posedge clk);
      #1;

      applyStimulus(MD_OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 2, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3");
      waitDrain(20);
      applyStimulus(MD_OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 2, 32'h00000002, 32'hFFFFFFFA, "multu_fffe_x3");
      waitDrain(20);

      applyStimulus(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
      waitDrain(60);
      applyStimulus(MD_OP_DIVU, 32'd100, 32'd7, 1'b1, 34, 32'd2, 32'd14, "divu_100_7");
      waitDrain(60);
      applyStimulus(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 34, 32'd0, 32'h80000000, "div_min_neg1");
      waitDrain(60);

      applyStimulus(MD_OP_DIVU, 32'd5, 32'd0, 1'b1, 1, 32'd5, 32'hFFFFFFFF, "divu_5_0");
      waitDrain(20);
      applyStimulus(MD_OP_DIV, 32'hFFFFFFF8, 32'd0, 1'b1, 1, 32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg8_0");
      waitDrain(20);

      // Start while busy is dropped; flush (with a start alongside) aborts cleanly.
      applyStimulus(MD_OP_DIV, 32'd100, 32'd7, 1'b0, 0, '0, '0, "div_flushed");
      repeat (4) @(posedge clk);
      #1;
      md.start = 1'b1;
      md.op    = MD_OP_MULTU;
      md.a     = 32'd3;
      md.b     = 32'd3;
      @(posedge clk);
      #1;
      md.start = 1'b0;
      checkOutput("busy_after_ignored_start", 32'(md.busy), 32'd1);
      repeat (14) @(posedge clk);
      #1;
      md.flush = 1'b1;
      md.start = 1'b1;
      md.op    = MD_OP_MULT;
      md.a     = 32'd2;
      md.b     = 32'd2;
      @(posedge clk);
      #1;
      md.flush = 1'b0;
      md.start = 1'b0;
      checkOutput("flush_busy", 32'(md.busy), 32'd0);
      checkOutput("flush_hi_kept", md.hi, 32'hFFFFFFF8);
      checkOutput("flush_lo_kept", md.lo, 32'hFFFFFFFF);
      applyStimulus(MD_OP_DIVU, 32'd9, 32'd4, 1'b1, 34, 32'd1, 32'd2, "divu_after_flush");
      waitDrain(60);

      mtWrite(1'b1, 32'h00001234);
      checkOutput("mthi_idle_hi", md.hi, 32'h00001234);
      checkOutput("mthi_idle_lo", md.lo, 32'd2);
      applyStimulus(MD_OP_MULTU, 32'd7, 32'd6, 1'b1, 2, 32'd0, 32'd42, "multu_7x6");
      md.lo_we = 1'b1;
      md.wdata = 32'h0000DEAD;
      @(posedge clk);
      #1;
      md.lo_we = 1'b0;
      checkOutput("mtlo_busy_ignored", md.lo, 32'd2);
      waitDrain(20);

      // Second op issued in the DONE cycle of the first runs with no bubble.
      applyStimulus(MD_OP_MULT, 32'd5, 32'hFFFFFFFD, 1'b1, 2, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_5xneg3");
      @(posedge clk);
      #1;
      checkOutput("busy_in_done", 32'(md.busy), 32'd0);
      applyStimulus(MD_OP_DIVU, 32'd50, 32'd6, 1'b1, 34, 32'd2, 32'd8, "divu_b2b");
      waitDrain(80);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
